// File: rtl/vec_pack_pkg.sv
// Shared widths, types and helpers for the vector frame packer.
// Frames are NUM_ELEMS beats of ELEM_W bits; beat 0 occupies the MSB element.
package vec_pack_pkg;

   localparam int unsigned ELEM_W    = 64;
   localparam int unsigned NUM_ELEMS = 16;
   localparam int unsigned OFF_W     = 32;
   localparam int unsigned VEC_W     = ELEM_W * NUM_ELEMS;
   localparam int unsigned IDX_W     = $clog2(NUM_ELEMS);

   typedef logic [ELEM_W-1:0] elem_t;
   typedef logic [VEC_W-1:0]  vec_t;
   typedef logic [OFF_W-1:0]  off_t;
   typedef logic [IDX_W-1:0]  idx_t;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } pack_state_t;

   typedef struct packed {
      vec_t vec;
      off_t off;
   } frame_t;

   localparam idx_t LAST_IDX = idx_t'(NUM_ELEMS - 1);

   // Write element e at position idx, counting from the MSB end of the vector.
   function automatic vec_t put_elem(input vec_t v, input idx_t idx, input elem_t e);
      vec_t r;
      r = v;
      for (int unsigned i = 0; i < NUM_ELEMS; i++) begin
         if (idx == idx_t'(i)) begin
            r[VEC_W-1-ELEM_W*i -: ELEM_W] = e;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/vec_out_slot.sv
// One-entry valid/ready output register for an assembled frame.
// free_c tells the producer a load this cycle will be accepted.
module vec_out_slot
   import vec_pack_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  frame_t load_frame,
   input  logic   out_ready,
   output logic   out_valid,
   output vec_t   out_vec,
   output off_t   out_offset,
   output logic   free_c
);

   logic   valid_q, valid_d;
   frame_t frame_q, frame_d;

   assign free_c = !valid_q || out_ready;

   // Payload only changes on load, so it stays stable while stalled.
   always_comb begin
      valid_d = valid_q;
      frame_d = frame_q;
      if (load) begin
         valid_d = 1'b1;
         frame_d = load_frame;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         frame_q <= '0;
      end else begin
         valid_q <= valid_d;
         frame_q <= frame_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_vec    = frame_q.vec;
   assign out_offset = frame_q.off;

endmodule

// File: rtl/vec_frame_packer.sv
// Assembles 64-bit beats into 1024-bit frames with a per-frame offset.
// Short frames are zero-padded; long frames are cut at 16 beats and the tail dropped.
module vec_frame_packer
   import vec_pack_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ELEM_W-1:0] in_data,
   input  logic              in_last,
   input  logic [OFF_W-1:0]  in_offset,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [VEC_W-1:0]  out_vec,
   output logic [OFF_W-1:0]  out_offset,
   output logic              err_short,
   output logic              err_long
);

   pack_state_t state_q, state_d;
   idx_t        idx_q, idx_d;
   vec_t        coll_q, coll_d;
   off_t        off_q, off_d;
   logic        long_q, long_d;
   logic        err_short_q, err_short_d;
   logic        err_long_q, err_long_d;

   logic        accept;
   logic        is_long;
   vec_t        beat_vec;
   logic        slot_free;
   logic        slot_load;
   frame_t      slot_frame;

   assign in_ready = (state_q != WAIT);
   assign accept   = in_valid && in_ready;
   assign beat_vec = put_elem(coll_q, idx_q, in_data);
   assign is_long  = (idx_q == LAST_IDX) && !in_last;

   // Next-state: collect, hand off to the slot, or park the frame until the slot frees.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      coll_d      = coll_q;
      off_d       = off_q;
      long_d      = long_q;
      err_short_d = 1'b0;
      err_long_d  = 1'b0;
      slot_load   = 1'b0;
      slot_frame  = '0;

      unique case (state_q)
         COLLECT: begin
            if (accept) begin
               if (in_last || (idx_q == LAST_IDX)) begin
                  idx_d       = '0;
                  err_short_d = in_last && (idx_q != LAST_IDX);
                  err_long_d  = is_long;
                  if (slot_free) begin
                     slot_load      = 1'b1;
                     slot_frame.vec = beat_vec;
                     slot_frame.off = in_offset;
                     coll_d         = '0;
                     state_d        = is_long ? DISCARD : COLLECT;
                  end else begin
                     coll_d  = beat_vec;
                     off_d   = in_offset;
                     long_d  = is_long;
                     state_d = WAIT;
                  end
               end else begin
                  coll_d = beat_vec;
                  idx_d  = idx_q + idx_t'(1);
               end
            end
         end
         WAIT: begin
            if (slot_free) begin
               slot_load      = 1'b1;
               slot_frame.vec = coll_q;
               slot_frame.off = off_q;
               coll_d         = '0;
               long_d         = 1'b0;
               state_d        = long_q ? DISCARD : COLLECT;
            end
         end
         DISCARD: begin
            if (accept && in_last) begin
               state_d = COLLECT;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= COLLECT;
         idx_q       <= '0;
         coll_q      <= '0;
         off_q       <= '0;
         long_q      <= 1'b0;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         coll_q      <= coll_d;
         off_q       <= off_d;
         long_q      <= long_d;
         err_short_q <= err_short_d;
         err_long_q  <= err_long_d;
      end
   end

   vec_out_slot u_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (slot_load),
      .load_frame (slot_frame),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_vec    (out_vec),
      .out_offset (out_offset),
      .free_c     (slot_free)
   );

   assign err_short = err_short_q;
   assign err_long  = err_long_q;

endmodule

// File: tb/tb_vec_frame_packer.sv
// Directed self-checking bench for vec_frame_packer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vec_frame_packer;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   in_data;
   logic          in_last;
   logic [31:0]   in_offset;
   logic          out_valid;
   logic          out_ready;
   logic [1023:0] out_vec;
   logic [31:0]   out_offset;
   logic          err_short;
   logic          err_long;

   int errors = 0;
   int checks = 0;

   vec_frame_packer dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_offset  (in_offset),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_vec    (out_vec),
      .out_offset (out_offset),
      .err_short  (err_short),
      .err_long   (err_long)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] elem(input logic [1023:0] v, input int i);
      return v[1023-64*i -: 64];
   endfunction

   function automatic int first_diff(input logic [1023:0] a, input logic [1023:0] b);
      for (int i = 0; i < 16; i++) begin
         if (elem(a, i) !== elem(b, i)) return i;
      end
      return 0;
   endfunction

   function automatic logic [1023:0] put(input logic [1023:0] v, input int i, input logic [63:0] d);
      logic [1023:0] r;
      r = v;
      r[1023-64*i -: 64] = d;
      return r;
   endfunction

   task automatic beat(input logic [63:0] d, input logic l, input logic [31:0] o);
      in_valid  = 1'b1;
      in_data   = d;
      in_last   = l;
      in_offset = o;
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_vec !== '0) begin errors++; $display("FAIL rst_out_vec got elem0=%h exp=0", elem(out_vec, 0)); end
      checks++; if (out_offset !== 32'h0) begin errors++; $display("FAIL rst_out_offset got=%h exp=0", out_offset); end
      checks++; if (err_short !== 1'b0 || err_long !== 1'b0) begin errors++; $display("FAIL rst_err got=%b%b exp=00", err_short, err_long); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_frame();
      logic [63:0]   d;
      logic [1023:0] exp_v;
      int            dv;
      exp_v = '0;
      out_ready = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         d = 64'h1111_1111_1111_1111 * 64'(k);
         exp_v = put(exp_v, k - 1, d);
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready beat %0d got=%b exp=1", k, in_ready); end
         beat(d, k == 16, (k == 16) ? 32'h5 : 32'(32'hFFFF_0000 + k));
         if (k < 16) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid beat %0d got=%b exp=0", k, out_valid); end
         end
      end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid got=%b exp=1", out_valid); end
      checks++; if (out_vec[1023:960] !== 64'h1111_1111_1111_1111) begin errors++; $display("FAIL full_msb got=%h exp=1111111111111111", out_vec[1023:960]); end
      checks++; if (out_vec[63:0] !== 64'h1111_1111_1111_1110) begin errors++; $display("FAIL full_lsb got=%h exp=1111111111111110", out_vec[63:0]); end
      checks++; if (out_vec !== exp_v) begin errors++; dv = first_diff(out_vec, exp_v); $display("FAIL full_vec elem %0d got=%h exp=%h", dv, elem(out_vec, dv), elem(exp_v, dv)); end
      checks++; if (out_offset !== 32'h5) begin errors++; $display("FAIL full_offset got=%h exp=5", out_offset); end
      checks++; if (err_short !== 1'b0 || err_long !== 1'b0) begin errors++; $display("FAIL full_err got=%b%b exp=00", err_short, err_long); end
      idle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_valid_drop got=%b exp=0", out_valid); end
      checks++; if (err_short !== 1'b0 || err_long !== 1'b0) begin errors++; $display("FAIL full_err_after got=%b%b exp=00", err_short, err_long); end
   endtask

   task automatic test_short();
      logic [63:0]   a, b, c;
      logic [1023:0] exp_v;
      int            dv;
      a = 64'hAAAA_0000_0000_000A;
      b = 64'hBBBB_0000_0000_000B;
      c = 64'hCCCC_0000_0000_000C;
      exp_v = {a, b, c, 832'h0};
      out_ready = 1'b1;
      beat(a, 1'b0, 32'h1);
      beat(b, 1'b0, 32'h2);
      beat(c, 1'b1, 32'hDEAD_BEEF);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL short_valid got=%b exp=1", out_valid); end
      checks++; if (out_vec !== exp_v) begin errors++; dv = first_diff(out_vec, exp_v); $display("FAIL short_vec elem %0d got=%h exp=%h", dv, elem(out_vec, dv), elem(exp_v, dv)); end
      checks++; if (out_offset !== 32'hDEAD_BEEF) begin errors++; $display("FAIL short_offset got=%h exp=deadbeef", out_offset); end
      checks++; if (err_short !== 1'b1 || err_long !== 1'b0) begin errors++; $display("FAIL short_err got=%b%b exp=10", err_short, err_long); end
      idle();
      checks++; if (err_short !== 1'b0) begin errors++; $display("FAIL short_err_pulse got=%b exp=0", err_short); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL short_valid_drop got=%b exp=0", out_valid); end
   endtask

   task automatic test_long();
      logic [63:0]   d, x, y;
      logic [1023:0] exp_v;
      int            dv;
      exp_v = '0;
      out_ready = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         d = 64'h0000_0100_0000_0000 + 64'(k);
         if (k <= 16) exp_v = put(exp_v, k - 1, d);
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL long_in_ready beat %0d got=%b exp=1", k, in_ready); end
         beat(d, k == 20, 32'(k));
         if (k == 16) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL long_valid got=%b exp=1", out_valid); end
            checks++; if (out_vec !== exp_v) begin errors++; dv = first_diff(out_vec, exp_v); $display("FAIL long_vec elem %0d got=%h exp=%h", dv, elem(out_vec, dv), elem(exp_v, dv)); end
            checks++; if (out_offset !== 32'd16) begin errors++; $display("FAIL long_offset got=%h exp=10", out_offset); end
            checks++; if (err_long !== 1'b1 || err_short !== 1'b0) begin errors++; $display("FAIL long_err got=%b%b exp=01", err_short, err_long); end
         end else if (k > 16) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL long_tail_valid beat %0d got=%b exp=0", k, out_valid); end
            checks++; if (err_long !== 1'b0 || err_short !== 1'b0) begin errors++; $display("FAIL long_tail_err beat %0d got=%b%b exp=00", k, err_short, err_long); end
         end
      end
      // Single-beat frames back to back: second completes while the first drains.
      x = 64'h0000_0000_00C0_FFEE;
      y = 64'h0000_0000_0BAD_F00D;
      beat(x, 1'b1, 32'h7);
      checks++; if (out_vec !== {x, 960'h0}) begin errors++; $display("FAIL one_vec got elem0=%h exp=%h", elem(out_vec, 0), x); end
      checks++; if (out_offset !== 32'h7) begin errors++; $display("FAIL one_offset got=%h exp=7", out_offset); end
      checks++; if (err_short !== 1'b1) begin errors++; $display("FAIL one_err_short got=%b exp=1", err_short); end
      beat(y, 1'b1, 32'h8);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL swap_valid got=%b exp=1", out_valid); end
      checks++; if (out_vec !== {y, 960'h0}) begin errors++; $display("FAIL swap_vec got elem0=%h exp=%h", elem(out_vec, 0), y); end
      checks++; if (out_offset !== 32'h8) begin errors++; $display("FAIL swap_offset got=%h exp=8", out_offset); end
      idle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL swap_valid_drop got=%b exp=0", out_valid); end
   endtask

   task automatic test_wait();
      logic [63:0]   d;
      logic [1023:0] f1, f2;
      int            dv;
      f1 = '0;
      f2 = '0;
      out_ready = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         d = ((k <= 16) ? 64'hAAAA_0000_0000_0000 : 64'hBBBB_0000_0000_0000) + 64'(k);
         if (k <= 16) f1 = put(f1, k - 1, d);
         else         f2 = put(f2, k - 17, d);
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wait_in_ready beat %0d got=%b exp=1", k, in_ready); end
         beat(d, (k == 16) || (k == 32), (k == 16) ? 32'hA : (k == 32) ? 32'hB : 32'h0);
         checks++; if (out_valid !== (k >= 16)) begin errors++; $display("FAIL wait_valid beat %0d got=%b exp=%b", k, out_valid, k >= 16); end
      end
      for (int c = 0; c < 3; c++) begin
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL wait_stall_ready cyc %0d got=%b exp=0", c, in_ready); end
         checks++; if (out_vec !== f1) begin errors++; dv = first_diff(out_vec, f1); $display("FAIL wait_hold_vec cyc %0d elem %0d got=%h exp=%h", c, dv, elem(out_vec, dv), elem(f1, dv)); end
         checks++; if (out_offset !== 32'hA) begin errors++; $display("FAIL wait_hold_offset cyc %0d got=%h exp=a", c, out_offset); end
         idle();
      end
      out_ready = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b1 || out_vec !== f1) begin errors++; $display("FAIL wait_drain1 valid=%b elem0 got=%h exp=%h", out_valid, elem(out_vec, 0), elem(f1, 0)); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wait_drain2_valid got=%b exp=1", out_valid); end
      checks++; if (out_vec !== f2) begin errors++; dv = first_diff(out_vec, f2); $display("FAIL wait_drain2_vec elem %0d got=%h exp=%h", dv, elem(out_vec, dv), elem(f2, dv)); end
      checks++; if (out_offset !== 32'hB) begin errors++; $display("FAIL wait_drain2_offset got=%h exp=b", out_offset); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wait_resume_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wait_empty got=%b exp=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [63:0]   d;
      logic [1023:0] f1, f2;
      int            dv;
      f1 = '0;
      f2 = '0;
      out_ready = 1'b1;
      for (int j = 1; j <= 32; j++) begin
         d = 64'h5555_0000_0000_0000 + 64'(j * 3);
         if (j <= 16) f1 = put(f1, j - 1, d);
         else         f2 = put(f2, j - 17, d);
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready beat %0d got=%b exp=1", j, in_ready); end
         beat(d, (j % 16) == 0, (j == 16) ? 32'h16 : (j == 32) ? 32'h32 : 32'hFFFF_FFFF);
         checks++; if (out_valid !== ((j == 16) || (j == 32))) begin errors++; $display("FAIL b2b_valid beat %0d got=%b exp=%b", j, out_valid, (j == 16) || (j == 32)); end
         if (j == 16) begin
            checks++; if (out_vec !== f1 || out_offset !== 32'h16) begin errors++; dv = first_diff(out_vec, f1); $display("FAIL b2b_frame1 elem %0d got=%h exp=%h off=%h", dv, elem(out_vec, dv), elem(f1, dv), out_offset); end
         end
         if (j == 32) begin
            checks++; if (out_vec !== f2 || out_offset !== 32'h32) begin errors++; dv = first_diff(out_vec, f2); $display("FAIL b2b_frame2 elem %0d got=%h exp=%h off=%h", dv, elem(out_vec, dv), elem(f2, dv), out_offset); end
            checks++; if (err_short !== 1'b0 || err_long !== 1'b0) begin errors++; $display("FAIL b2b_err got=%b%b exp=00", err_short, err_long); end
         end
      end
      idle();
   endtask

   task automatic test_reset_mid();
      logic [63:0] p, q;
      p = 64'h0123_4567_89AB_CDEF;
      q = 64'hFEDC_BA98_7654_3210;
      out_ready = 1'b0;
      for (int k = 1; k <= 16; k++) beat(64'hDDDD_0000_0000_0000 + 64'(k), k == 16, 32'h99);
      for (int k = 1; k <= 6; k++) beat(64'hEEEE_0000_0000_0000 + 64'(k), 1'b0, 32'h0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got=%b exp=1", out_valid); end
      in_valid  = 1'b1;
      in_data   = 64'hEEEE_0000_0000_0007;
      in_last   = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_async_valid got=%b exp=0", out_valid); end
      checks++; if (out_vec !== '0 || out_offset !== 32'h0) begin errors++; $display("FAIL rmid_clear got elem0=%h off=%h exp=0", elem(out_vec, 0), out_offset); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      rst = 1'b0;
      idle();
      out_ready = 1'b1;
      beat(p, 1'b0, 32'h0);
      beat(q, 1'b1, 32'h77);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_post_valid got=%b exp=1", out_valid); end
      checks++; if (out_vec !== {p, q, 896'h0}) begin errors++; $display("FAIL rmid_post_vec e0=%h e1=%h e2=%h", elem(out_vec, 0), elem(out_vec, 1), elem(out_vec, 2)); end
      checks++; if (out_offset !== 32'h77) begin errors++; $display("FAIL rmid_post_offset got=%h exp=77", out_offset); end
      checks++; if (err_short !== 1'b1) begin errors++; $display("FAIL rmid_post_err_short got=%b exp=1", err_short); end
      idle();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      in_offset = '0;
      out_ready = 1'b1;
      test_reset();
      test_full_frame();
      test_short();
      test_long();
      test_wait();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
